imm_encoder_loader: RTL and testbench
=====================================

Name: imm_encoder_loader

Overview:
- Inverse of the core's immediate extender: takes a full 32-bit immediate and the ImmSrc format code (I/S/B/U), range-checks it, and scatters its bits into the instruction word.
- Streams the resulting instructions into instruction memory at consecutive word addresses.
- Used by the test/boot loader path to build programs in-system ahead of core release.

Parameters:
- ADDR_WIDTH, 32, width of instruction-memory byte address.
- LEN_WIDTH, 16, width of the word-count and error-count fields.
- NOP_WORD, 32'h00000013, word written in place of an unencodable instruction (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load burst; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  byte address of first word; bits [1:0] are ignored (treated as 0).
- len  input  LEN_WIDTH  number of words in the burst.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at burst end.
- in_valid  input  1  encode request valid.
- in_ready  output  1  encoder accepts a request this cycle.
- in_base  input  32  instruction with opcode/rd/rs/funct fields; immediate bit positions are don't-care.
- in_imm  input  32  immediate value in the same form ImmExt produces.
- in_imm_src  input  2  format: 00=I, 01=S, 10=B, 11=U.
- wr_en  output  1  instruction-memory write strobe; memory never back-pressures.
- wr_addr  output  ADDR_WIDTH  write byte address.
- wr_data  output  32  encoded instruction.
- err  output  1  sticky: some word in the current/last burst was unencodable.
- err_count  output  LEN_WIDTH  number of unencodable words in the burst; saturates at all-ones.

Behaviour:
- Reset: state=IDLE; busy, done, in_ready, wr_en, err = 0; wr_addr, wr_data, err_count = 0. Reset mid-burst aborts with no further writes.
- States IDLE, RUN, FIN.
  - IDLE + start: load addr=base_addr&~3, remaining=len, clear err/err_count; go to RUN if len!=0, else FIN.
  - RUN: in_ready=1. On accept (in_valid&in_ready): remaining--; if remaining was 1, go to FIN.
  - FIN: done=1 for exactly one cycle, in_ready=0, then IDLE.
  - start outside IDLE is ignored.
- Latency: one cycle. A word accepted in cycle N gives wr_en=1 in N+1 with wr_addr=addr; addr then advances by 4 (wraps modulo 2^ADDR_WIDTH). The last word's wr_en coincides with done. wr_en=0 in all other cycles; wr_addr/wr_data hold their last values.
- Encoding: word = in_base with the immediate positions replaced. Non-immediate bits pass through unchanged.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
- Range checks (imm is signed 32-bit):
  - I/S: -2048..2047.
  - B: -4096..4094 and imm[0]==0.
  - U: imm[11:0]==0.
- Failing word: wr_data=NOP_WORD and the address still advances; err set; err_count+=1, saturating.
- err/err_count hold after done until the next accepted start.

Decomposition:
- Shared package (riscv_pkg): imm_src_t enum {IMM_I, IMM_S, IMM_B, IMM_U} replacing the bare 2-bit codes, shared with the extender; NOP_WORD constant; loader state enum.
- One combinational sub-module, imm_scatter: inputs in_base, in_imm, in_imm_src; outputs encoded word and ok flag. The top holds the FSM, counters and output register.
- A bench round-trip check passes each written word through the existing extender and compares against in_imm.

Test Plan:
- start, base_addr=0x100, len=4 with I imm=-1, S imm=0x7FF, B imm=-4096, U imm=0xABCDE000 → writes at 0x100, 0x104, 0x108, 0x10C. Data checked against the field maps (I word has [31:20]=0xFFF; U word has [31:12]=0xABCDE). done on the 4th wr_en; err=0.
- B imm=0x1001 (odd) and I imm=2048 inside len=3 → two NOP_WORD writes at correct addresses; err=1, err_count=2; the valid word is encoded normally.
- in_valid toggling 1,0,0,1,1 with len=3 → exactly 3 writes, each one cycle after its accept. in_ready=0 in FIN and in IDLE after done.
- start with len=0 → busy for one cycle with done=1, no wr_en. A second start during RUN is ignored (address and count unaffected).
- rst asserted after the 2nd of 5 accepts → next cycle: all outputs 0, state IDLE, no further wr_en. A new start with base_addr=0x203 loads address 0x200.
- base_addr=0xFFFFFFFC, len=2 → writes at 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: immediate format codes,
// the canonical NOP and the program loader state set.
package riscv_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_U = 2'b11
    } imm_src_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Bits that must all equal the sign for a 12-bit signed field
    localparam logic [31:0] HI_MASK_12 = 32'hFFFF_F800;

    // Bits that must all equal the sign for a 13-bit signed field
    localparam logic [31:0] HI_MASK_13 = 32'hFFFF_F000;

    typedef enum logic [1:0] {
        LD_IDLE = 2'b00,
        LD_RUN  = 2'b01,
        LD_FIN  = 2'b10
    } ld_state_t;

    // True when the masked upper bits are all zero or all one,
    // i.e. the value survives truncation plus sign extension.
    function automatic logic upper_uniform(
        input logic [31:0] v,
        input logic [31:0] mask
    );
        logic [31:0] hi;
        hi = v & mask;
        return (hi == mask) || (hi == 32'h0);
    endfunction

endpackage

// File: rtl/imm_scatter.sv
// Immediate encoder: places a 32-bit immediate into the
// instruction-format bit positions and flags values that do not fit.
module imm_scatter
    import riscv_pkg::*;
(
    input  logic [31:0] in_base,
    input  logic [31:0] in_imm,
    input  imm_src_t    in_imm_src,
    output logic [31:0] word,
    output logic        ok
);

    // Overlay immediate fields onto the base instruction and range-check
    always_comb begin
        word = in_base;
        ok   = 1'b0;
        unique case (in_imm_src)
            IMM_I: begin
                word[31:20] = in_imm[11:0];
                ok = upper_uniform(in_imm, HI_MASK_12);
            end
            IMM_S: begin
                word[31:25] = in_imm[11:5];
                word[11:7]  = in_imm[4:0];
                ok = upper_uniform(in_imm, HI_MASK_12);
            end
            IMM_B: begin
                word[31]    = in_imm[12];
                word[30:25] = in_imm[10:5];
                word[11:8]  = in_imm[4:1];
                word[7]     = in_imm[11];
                ok = upper_uniform(in_imm, HI_MASK_13)
                   & ~in_imm[0];
            end
            IMM_U: begin
                word[31:12] = in_imm[31:12];
                ok = ~|in_imm[11:0];
            end
            default: begin
                word = in_base;
                ok   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder_loader.sv
// Program loader: encodes instruction immediates and streams
// the words into instruction memory at consecutive addresses.
module imm_encoder_loader #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          LEN_WIDTH  = 16,
    parameter logic [31:0] NOP_WORD   = riscv_pkg::NOP_WORD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_base,
    input  logic [31:0]           in_imm,
    input  logic [1:0]            in_imm_src,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  err_count
);
    import riscv_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(4);
    localparam logic [LEN_WIDTH-1:0]  ONE   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  SAT   = '1;

    ld_state_t             state;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           enc_word;
    logic                  enc_ok;
    logic                  load;
    logic                  accept;

    assign load   = (state == LD_IDLE) & start;
    assign accept = in_valid & in_ready;

    imm_scatter u_scatter (
        .in_base    (in_base),
        .in_imm     (in_imm),
        .in_imm_src (imm_src_t'(in_imm_src)),
        .word       (enc_word),
        .ok         (enc_ok)
    );

    // Burst sequencing with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LD_IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                LD_IDLE: begin
                    if (start) begin
                        remaining <= len;
                        busy      <= 1'b1;
                        if (len != '0) begin
                            state    <= LD_RUN;
                            in_ready <= 1'b1;
                        end else begin
                            state <= LD_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                LD_RUN: begin
                    if (accept) begin
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state    <= LD_FIN;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                LD_FIN: begin
                    state <= LD_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= LD_IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Write port register, address walk and error bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            wr_en <= 1'b0;
            if (load) begin
                addr      <= base_addr & ALIGN;
                err       <= 1'b0;
                err_count <= '0;
            end else if (accept) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                addr    <= addr + STEP;
                wr_data <= enc_ok ? enc_word : NOP_WORD;
                if (!enc_ok) begin
                    err <= 1'b1;
                    if (err_count != SAT) begin
                        err_count <= err_count + ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder_loader.sv
// Bench for imm_encoder_loader: directed and random bursts,
// each written word decoded by the core extender and compared.
module tb_imm_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] len = '0;
    logic        busy;
    logic        done;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_base = '0;
    logic [31:0] in_imm = '0;
    logic [1:0]  in_imm_src = '0;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        err;
    logic [15:0] err_count;

    imm_encoder_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_base    (in_base),
        .in_imm     (in_imm),
        .in_imm_src (in_imm_src),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .err        (err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] w_addr[$];
    logic [31:0] w_data[$];
    int          w_cyc[$];
    int          d_cyc[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            w_addr.push_back(wr_addr);
            w_data.push_back(wr_data);
            w_cyc.push_back(cyc);
        end
        if (done === 1'b1) d_cyc.push_back(cyc);
    end

    logic [31:0] s_base[$];
    logic [31:0] s_imm[$];
    logic [1:0]  s_src[$];

    logic [31:0] e_addr[$];
    logic [31:0] e_base[$];
    logic [31:0] e_imm[$];
    logic [1:0]  e_src[$];
    int          e_cyc[$];

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Core immediate extender (ImmExt), used as the decoder
    function automatic logic [31:0] extend(
        input logic [31:0] w, input logic [1:0] src);
        case (src)
            2'd0: return {{20{w[31]}}, w[31:20]};
            2'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
            2'd2: return {{19{w[31]}}, w[31], w[7],
                          w[30:25], w[11:8], 1'b0};
            default: return {w[31:12], 12'h000};
        endcase
    endfunction

    function automatic logic [31:0] imm_mask(input logic [1:0] src);
        case (src)
            2'd0: return 32'hFFF0_0000;
            2'd3: return 32'hFFFF_F000;
            default: return 32'hFE00_0F80;
        endcase
    endfunction

    function automatic bit encodable(
        input logic [31:0] imm, input logic [1:0] src);
        int s;
        s = $signed(imm);
        case (src)
            2'd0, 2'd1: return (s >= -2048) && (s <= 2047);
            2'd2: return (s >= -4096) && (s <= 4094)
                         && (s % 2 == 0);
            default: return (imm % 4096) == 0;
        endcase
    endfunction

    function automatic logic [31:0] rand_imm(input logic [1:0] src);
        int v;
        if ($urandom_range(0, 3) == 0) return $urandom;
        v = int'($urandom_range(0, 4095)) - 2048;
        case (src)
            2'd0, 2'd1: return v;
            2'd2: return v * 2;
            default: return $urandom & 32'hFFFF_F000;
        endcase
    endfunction

    task automatic add(input logic [31:0] b,
                       input logic [31:0] imm,
                       input logic [1:0] src);
        s_base.push_back(b);
        s_imm.push_back(imm);
        s_src.push_back(src);
    endtask

    task automatic clear_obs();
        w_addr.delete(); w_data.delete();
        w_cyc.delete(); d_cyc.delete();
        e_addr.delete(); e_base.delete();
        e_imm.delete(); e_src.delete(); e_cyc.delete();
    endtask

    // Called at a negedge with the DUT idle; runs one burst
    // of the words queued in s_*, then verifies the writes.
    task automatic burst(input logic [31:0] base,
                         input int vmode,
                         input bit restart);
        int n, k, p, guard, nbad, c0, m;
        logic [31:0] al;
        bit v;
        bit pat[5] = '{1, 0, 0, 1, 1};
        n = s_imm.size();
        k = 0; p = 0; guard = 0; nbad = 0;
        al = base - (base % 4);
        clear_obs();
        start = 1'b1;
        base_addr = base;
        len = 16'(n);
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (k < n && guard < 200) begin
            check("in_ready_run", in_ready, 1);
            check("busy_run", busy, 1);
            case (vmode)
                0: v = 1'b1;
                1: v = pat[p % 5];
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (restart && p == 1) begin
                start = 1'b1;
                base_addr = base + 32'h40;
                len = 16'd7;
            end
            p++;
            in_valid = v;
            if (v) begin
                in_base = s_base[k];
                in_imm = s_imm[k];
                in_imm_src = s_src[k];
                e_addr.push_back(al + 32'(4 * k));
                e_base.push_back(s_base[k]);
                e_imm.push_back(s_imm[k]);
                e_src.push_back(s_src[k]);
                e_cyc.push_back(cyc + 1);
                if (!encodable(s_imm[k], s_src[k])) nbad++;
                k++;
            end else begin
                in_base = $urandom;
                in_imm = $urandom;
                in_imm_src = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            start = 1'b0;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 200) check("burst_timeout", 0, 1);
        check("fin_done", done, 1);
        check("fin_busy", busy, 1);
        check("fin_in_ready", in_ready, 0);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_in_ready", in_ready, 0);
        @(negedge clk);
        check("n_writes", w_addr.size(), n);
        check("n_done", d_cyc.size(), 1);
        if (d_cyc.size() > 0)
            check("done_cyc", d_cyc[0],
                  n > 0 ? e_cyc[n - 1] : c0 + 1);
        m = w_addr.size() < n ? w_addr.size() : n;
        for (int i = 0; i < m; i++) begin
            check("wr_addr", w_addr[i], e_addr[i]);
            check("wr_cyc", w_cyc[i], e_cyc[i]);
            if (encodable(e_imm[i], e_src[i])) begin
                check("keep_bits",
                      w_data[i] & ~imm_mask(e_src[i]),
                      e_base[i] & ~imm_mask(e_src[i]));
                check("roundtrip",
                      extend(w_data[i], e_src[i]), e_imm[i]);
            end else begin
                check("nop_word", w_data[i], 32'h0000_0013);
            end
        end
        check("err", err, nbad > 0);
        check("err_count", err_count, nbad);
        s_base.delete(); s_imm.delete(); s_src.delete();
    endtask

    initial begin
        int n;
        logic [1:0] src;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_err", err, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_err_count", err_count, 0);
        rst = 1'b0;
        @(negedge clk);

        add(32'h0000_0513, 32'hFFFF_FFFF, 2'd0);
        add(32'h00A1_2023, 32'h0000_07FF, 2'd1);
        add(32'h0020_8063, 32'hFFFF_F000, 2'd2);
        add(32'h0000_02B7, 32'hABCD_E000, 2'd3);
        burst(32'h100, 0, 0);
        if (w_data.size() == 4) begin
            check("i_field", w_data[0] >> 20, 32'hFFF);
            check("u_field", w_data[3] >> 12, 32'hABCDE);
            check("i_addr0", w_addr[0], 32'h100);
            check("u_addr3", w_addr[3], 32'h10C);
        end

        add(32'h0020_8063, 32'h0000_1001, 2'd2);
        add(32'h00A1_2023, 32'hFFFF_F800, 2'd1);
        add(32'h0000_0513, 32'd2048, 2'd0);
        burst(32'h180, 0, 0);
        check("bad_err", err, 1);
        check("bad_count", err_count, 2);

        add(32'h0000_0593, 32'd12, 2'd0);
        add(32'h0000_0613, 32'hFFFF_FFF0, 2'd0);
        add(32'h0000_0693, 32'd100, 2'd0);
        burst(32'h200, 1, 0);
        check("err_held", err, 0);

        burst(32'h500, 0, 0);

        for (int i = 0; i < 4; i++)
            add(32'h0000_0013, 32'(i * 8), 2'd2);
        burst(32'h600, 0, 1);

        clear_obs();
        start = 1'b1; base_addr = 32'h300; len = 16'd5;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_base = 32'h0000_0093;
        in_imm = 32'd5000;
        in_imm_src = 2'd0;
        @(negedge clk);
        in_imm = 32'd1;
        @(negedge clk);
        check("pre_rst_err", err, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_in_ready", in_ready, 0);
        check("mid_wr_en", wr_en, 0);
        check("mid_err", err, 0);
        check("mid_wr_addr", wr_addr, 0);
        check("mid_wr_data", wr_data, 0);
        check("mid_err_count", err_count, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("rst_n_writes", w_addr.size(), 2);
        if (w_addr.size() >= 2) begin
            check("rst_addr0", w_addr[0], 32'h300);
            check("rst_addr1", w_addr[1], 32'h304);
        end

        add(32'h0000_0013, 32'd4, 2'd0);
        burst(32'h203, 0, 0);
        if (w_addr.size() > 0)
            check("align_addr", w_addr[0], 32'h200);

        add(32'h0000_0013, 32'd1, 2'd0);
        add(32'h0000_0013, 32'd2, 2'd0);
        burst(32'hFFFF_FFFC, 0, 0);
        if (w_addr.size() == 2)
            check("wrap_addr", w_addr[1], 32'h0);

        for (int b = 0; b < 8; b++) begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                src = 2'($urandom_range(0, 3));
                add($urandom, rand_imm(src), src);
            end
            burst($urandom, 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
